// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: six-lamp rear turn-signal sequencer.
// Arbitrates left/right/hazard requests and steps a 1-2-3 lamp animation.
// Each step lasts TICK_DIV clock cycles, paced by an internal prescaler.
// Optional brake overlay is compiled in when TURN_SIGNAL_BRAKE_EN is defined.
// Without it, brake is ignored and no brake state is kept.
// Lamp vectors are {x3,x2,x1}, so bit 0 is the inner lamp.
module turn_signal_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  input  logic brake,
  output logic L1,
  output logic L2,
  output logic L3,
  output logic R1,
  output logic R2,
  output logic R3,
  output logic busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP1 = 3'd1,
    S_STEP2 = 3'd2,
    S_STEP3 = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'd0,
    MODE_RIGHT = 2'd1,
    MODE_BOTH  = 2'd2
  } mode_t;

  state_t           r_state;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_l;
  logic [2:0]       r_r;
  logic             r_busy;

  state_t           w_state_nxt;
  mode_t            w_mode_nxt;
  mode_t            w_arb_mode;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_pat;
  logic [2:0]       w_l_nxt;
  logic [2:0]       w_r_nxt;
  logic             w_req;
  logic             w_tick;
  logic             w_state_ok;

`ifndef TURN_SIGNAL_BRAKE_EN
  // Brake port stays on the interface but has no function in this build.
  logic w_unused_brake;
  assign w_unused_brake = brake;
`endif

  // Animation pattern shown on an animated side for a given state.
  function automatic logic [2:0] step_pat(input state_t s);
    case (s)
      S_STEP1: step_pat = 3'b001;
      S_STEP2: step_pat = 3'b011;
      S_STEP3: step_pat = 3'b111;
      default: step_pat = 3'b000;
    endcase
  endfunction

  assign w_req  = hazard | left | right;
  assign w_tick = (r_cnt == CNT_LAST);

  // Arbitration, next state, prescaler and next lamp image.
  always_comb begin
    w_arb_mode  = MODE_RIGHT;
    if (hazard || (left && right)) w_arb_mode = MODE_BOTH;
    else if (left)                 w_arb_mode = MODE_LEFT;

    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_state_ok  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_STEP1;
          w_mode_nxt  = w_arb_mode;
        end
      end
      S_STEP1: if (w_tick) w_state_nxt = S_STEP2;
      S_STEP2: if (w_tick) w_state_nxt = S_STEP3;
      S_STEP3: if (w_tick) w_state_nxt = S_GAP;
      S_GAP: begin
        if (w_tick) begin
          if (w_req) begin
            w_state_nxt = S_STEP1;
            w_mode_nxt  = w_arb_mode;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_state_ok  = 1'b0;
      end
    endcase

    // Every state change, and all of IDLE, restarts the prescaler.
    if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE)) w_cnt_nxt = '0;
    else                                                       w_cnt_nxt = CNT_W'(r_cnt + 1'b1);

    w_pat   = step_pat(w_state_nxt);
    w_l_nxt = 3'b000;
    w_r_nxt = 3'b000;
    case (w_mode_nxt)
      MODE_LEFT:  w_l_nxt = w_pat;
      MODE_RIGHT: w_r_nxt = w_pat;
      MODE_BOTH: begin
        w_l_nxt = w_pat;
        w_r_nxt = w_pat;
      end
      default: ;
    endcase

`ifdef TURN_SIGNAL_BRAKE_EN
    // Brake lights every non-animated side; in IDLE that is both sides.
    if (brake) begin
      if (w_state_nxt == S_IDLE) begin
        w_l_nxt = 3'b111;
        w_r_nxt = 3'b111;
      end else if (w_mode_nxt == MODE_LEFT) begin
        w_r_nxt = 3'b111;
      end else if (w_mode_nxt == MODE_RIGHT) begin
        w_l_nxt = 3'b111;
      end
    end
`endif

    // Recovery from an illegal encoding shows dark lamps.
    if (!w_state_ok) begin
      w_l_nxt = 3'b000;
      w_r_nxt = 3'b000;
    end
  end

  // Sequencer state, mode, prescaler and registered lamp/busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_LEFT;
      r_cnt   <= '0;
      r_l     <= 3'b000;
      r_r     <= 3'b000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_l     <= w_l_nxt;
      r_r     <= w_r_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign L1   = r_l[0];
  assign L2   = r_l[1];
  assign L3   = r_l[2];
  assign R1   = r_r[0];
  assign R2   = r_r[1];
  assign R3   = r_r[2];
  assign busy = r_busy;

endmodule
